// File: rtl/router_n.sv
`default_nettype none
// ============================================================================
// Module   : router_n
// Brief    : PORTS-channel NoC router: per-input FIFOs, shared route lookup,
//            per-output round-robin switch into registered tx channels.
// Revision : 1.0
// ============================================================================
module router_n #(
    parameter int ID       = -1,
    parameter int PORTS    = 5,
    parameter int SIZE     = 8,
    parameter int DEPTH    = 4,
    parameter int BITS_DIR = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PORTS-1:0]      rx_req,
    output logic [PORTS-1:0]      rx_ack,
    input  logic [PORTS*SIZE-1:0] rx_data,
    output logic [PORTS-1:0]      tx_req,
    input  logic [PORTS-1:0]      tx_ack,
    output logic [PORTS*SIZE-1:0] tx_data,
    output logic [SIZE-1:0]       table_addr,
    input  logic [BITS_DIR-1:0]   table_data,
    output logic [15:0]           drop_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam logic [BITS_DIR:0] c_PORTS_W = (BITS_DIR + 1)'(PORTS);
    localparam logic [c_AW:0]     c_FULL    = (c_AW + 1)'(DEPTH);
    // Router id is only meaningful to mesh-level tracing.
    localparam int c_unused_id = ID;

    logic [SIZE-1:0]       r_mem [PORTS][DEPTH];
    logic [c_AW-1:0]       r_wr_ptr [PORTS];
    logic [c_AW-1:0]       r_rd_ptr [PORTS];
    logic [c_AW:0]         r_count [PORTS];
    logic [PORTS-1:0]      r_route_valid;
    logic [BITS_DIR-1:0]   r_dir [PORTS];
    logic [c_PW-1:0]       r_lk_ptr;
    logic [c_PW-1:0]       r_gr_ptr [PORTS];
    logic [PORTS-1:0]      r_tx_req;
    logic [PORTS*SIZE-1:0] r_tx_data;
    logic [15:0]           r_drop_count;
    logic                  r_alive;

    logic [SIZE-1:0]       w_head [PORTS];
    logic [PORTS-1:0]      w_full;
    logic [PORTS-1:0]      w_empty;
    logic [PORTS-1:0]      w_push;
    logic [PORTS-1:0]      w_pending;
    logic [PORTS-1:0]      w_pop_gnt;
    logic [PORTS-1:0]      w_pop_drop;
    logic [PORTS-1:0]      w_pop;
    logic [PORTS-1:0]      w_out_free;
    logic [PORTS-1:0]      w_gnt_valid;
    logic [c_PW-1:0]       w_gnt_idx [PORTS];
    logic                  w_lk_found;
    logic [c_PW-1:0]       w_lk_sel;
    logic                  w_tbl_ok;

    function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
        return (p == c_PW'(PORTS - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar k = 0; k < PORTS; k++) begin : g_port
        assign w_head[k]     = r_mem[k][r_rd_ptr[k]];
        assign w_full[k]     = (r_count[k] == c_FULL);
        assign w_empty[k]    = (r_count[k] == '0);
        // Registered occupancy only: a same-cycle pop never frees a full FIFO.
        assign rx_ack[k]     = r_alive & ~w_full[k];
        assign w_push[k]     = rx_req[k] & rx_ack[k];
        assign w_pending[k]  = ~w_empty[k] & ~r_route_valid[k];
        assign w_out_free[k] = ~r_tx_req[k] | tx_ack[k];
    end

    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_lk_found = 1'b0;
        w_lk_sel   = '0;
        for (int i = 0; i < PORTS; i++) begin
            v_idx = int'(r_lk_ptr) + i;
            if (v_idx >= PORTS) v_idx = v_idx - PORTS;
            if (!w_lk_found && w_pending[c_PW'(v_idx)]) begin
                w_lk_found = 1'b1;
                w_lk_sel   = c_PW'(v_idx);
            end
        end
    end

    assign w_tbl_ok   = ({1'b0, table_data} < c_PORTS_W);
    assign table_addr = w_lk_found ? w_head[w_lk_sel] : '0;

    always_comb begin
        w_pop_drop = '0;
        if (w_lk_found && !w_tbl_ok) w_pop_drop[w_lk_sel] = 1'b1;
    end

    // An input holds at most one route, so no input can win two outputs.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_gnt_valid = '0;
        w_pop_gnt   = '0;
        for (int o = 0; o < PORTS; o++) w_gnt_idx[o] = '0;
        for (int o = 0; o < PORTS; o++) begin
            if (w_out_free[o]) begin
                for (int i = 0; i < PORTS; i++) begin
                    v_idx = int'(r_gr_ptr[o]) + i;
                    if (v_idx >= PORTS) v_idx = v_idx - PORTS;
                    if (!w_gnt_valid[o] && r_route_valid[c_PW'(v_idx)] &&
                        (r_dir[c_PW'(v_idx)] == BITS_DIR'(o))) begin
                        w_gnt_valid[o]            = 1'b1;
                        w_gnt_idx[o]              = c_PW'(v_idx);
                        w_pop_gnt[c_PW'(v_idx)] = 1'b1;
                    end
                end
            end
        end
    end

    assign w_pop = w_pop_gnt | w_pop_drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alive       <= 1'b0;
            r_route_valid <= '0;
            r_lk_ptr      <= '0;
            r_tx_req      <= '0;
            r_tx_data     <= '0;
            r_drop_count  <= '0;
            for (int k = 0; k < PORTS; k++) begin
                r_wr_ptr[k] <= '0;
                r_rd_ptr[k] <= '0;
                r_count[k]  <= '0;
                r_dir[k]    <= '0;
                r_gr_ptr[k] <= '0;
            end
        end else begin
            r_alive <= 1'b1;
            for (int k = 0; k < PORTS; k++) begin
                if (w_push[k]) r_wr_ptr[k] <= r_wr_ptr[k] + 1'b1;
                if (w_pop[k])  r_rd_ptr[k] <= r_rd_ptr[k] + 1'b1;
                r_count[k] <= r_count[k] + (c_AW + 1)'(w_push[k]) - (c_AW + 1)'(w_pop[k]);
                if (w_pop_gnt[k]) r_route_valid[k] <= 1'b0;
            end
            if (w_lk_found) begin
                r_lk_ptr <= f_next(w_lk_sel);
                if (w_tbl_ok) begin
                    r_route_valid[w_lk_sel] <= 1'b1;
                    r_dir[w_lk_sel]         <= table_data;
                end else if (r_drop_count != 16'hFFFF) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
            for (int o = 0; o < PORTS; o++) begin
                if (w_gnt_valid[o]) begin
                    r_tx_req[o]                <= 1'b1;
                    r_tx_data[o*SIZE +: SIZE]  <= w_head[w_gnt_idx[o]];
                    r_gr_ptr[o]                <= f_next(w_gnt_idx[o]);
                end else if (tx_ack[o]) begin
                    r_tx_req[o] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < PORTS; k++) begin
            if (w_push[k]) r_mem[k][r_wr_ptr[k]] <= rx_data[k*SIZE +: SIZE];
        end
    end

    assign tx_req     = r_tx_req;
    assign tx_data    = r_tx_data;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_router_n.sv
`default_nettype none
// tb_router_n: directed checks on the default router plus a randomized
// scoreboard run on a PORTS=3 / SIZE=16 / DEPTH=8 / BITS_DIR=2 instance.
module tb_router_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // default-parameter instance
    logic [4:0]  rx_req0, rx_ack0, tx_req0, tx_ack0;
    logic [39:0] rx_data0, tx_data0;
    logic [7:0]  table_addr0;
    logic [2:0]  table_data0, tbl_val;
    logic [15:0] drop_count0;
    assign table_data0 = tbl_val;

    // small instance: route = low two flit bits (3 is invalid)
    logic [2:0]  rx_req1, rx_ack1, tx_req1, tx_ack1;
    logic [47:0] rx_data1, tx_data1;
    logic [15:0] table_addr1;
    logic [1:0]  table_data1;
    logic [15:0] drop_count1;
    assign table_data1 = table_addr1[1:0];

    router_n #(.ID(7)) u_dut0 (
        .clk(clk), .reset(rst_n),
        .rx_req(rx_req0), .rx_ack(rx_ack0), .rx_data(rx_data0),
        .tx_req(tx_req0), .tx_ack(tx_ack0), .tx_data(tx_data0),
        .table_addr(table_addr0), .table_data(table_data0),
        .drop_count(drop_count0)
    );

    router_n #(.ID(1), .PORTS(3), .SIZE(16), .DEPTH(8), .BITS_DIR(2)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .rx_req(rx_req1), .rx_ack(rx_ack1), .rx_data(rx_data1),
        .tx_req(tx_req1), .tx_ack(tx_ack1), .tx_data(tx_data1),
        .table_addr(table_addr1), .table_data(table_data1),
        .drop_count(drop_count1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  got0[$];
    logic [15:0] expq[9][$];
    int drops_exp = 0;
    bit rnd_stop  = 1'b0;
    bit rnd_drain = 1'b0;
    int rr_pat[3] = '{0, 1, 3};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        sync();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sync();
    endtask

    // Called just after a rising edge; returns just after the transfer edge.
    task automatic send0(input int p, input logic [7:0] d, input int budget, output bit ok);
        bit acked;
        rx_req0[p] = 1'b1;
        rx_data0[p*8 +: 8] = d;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            acked = rx_ack0[p];
            @(posedge clk);
            #1;
            ok = acked;
        end
        rx_req0[p] = 1'b0;
    endtask

    task automatic send1(input int p, input logic [15:0] d, input int budget, output bit ok);
        bit acked;
        rx_req1[p] = 1'b1;
        rx_data1[p*16 +: 16] = d;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            acked = rx_ack1[p];
            if (acked) begin
                if (d[1:0] == 2'd3) drops_exp++;
                else expq[p*3 + int'(d[1:0])].push_back(d);
            end
            @(posedge clk);
            #1;
            ok = acked;
        end
        rx_req1[p] = 1'b0;
    endtask

    task automatic collect0(input int o, input int cycles);
        got0.delete();
        repeat (cycles) begin
            @(negedge clk);
            if (tx_req0[o] && tx_ack0[o]) got0.push_back(tx_data0[o*8 +: 8]);
        end
    endtask

    task automatic stream0(input int p);
        bit ok;
        for (int s = 0; s < 12; s++) begin
            send0(p, {3'(p), 5'(s)}, 20, ok);
            if (!ok) chk("rr_send_accept", 64'(ok), 64'd1);
        end
    endtask

    task automatic sender1(input int p);
        bit ok;
        logic [15:0] d;
        for (int s = 0; s < 60; s++) begin
            repeat ($urandom_range(0, 2)) sync();
            d = {2'(p), 12'(s), 2'($urandom_range(0, 3))};
            send1(p, d, 400, ok);
            if (!ok) chk("rnd_send_accept", 64'(ok), 64'd1);
        end
    endtask

    task automatic monitor1;
        logic [15:0] f;
        int s, qsz;
        while (!rnd_stop) begin
            @(negedge clk);
            for (int o = 0; o < 3; o++) begin
                if (tx_req1[o] && tx_ack1[o]) begin
                    f   = tx_data1[o*16 +: 16];
                    s   = int'(f[15:14]);
                    qsz = (s < 3) ? expq[s*3 + o].size() : 0;
                    chk("rnd_route", 64'(f[1:0]), 64'(o));
                    chk("rnd_expected", 64'(qsz != 0), 64'd1);
                    if (qsz != 0) chk("rnd_flit", 64'(f), 64'(expq[s*3 + o].pop_front()));
                end
            end
        end
    endtask

    task automatic ack_driver1;
        while (!rnd_stop) begin
            sync();
            tx_ack1 = rnd_drain ? 3'b111 : 3'($urandom);
        end
    endtask

    initial begin
        #(10 * 98000);
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit seen;
        logic [7:0] g;
        int src;

        rst_n    = 1'b0;
        rx_req0  = '0; rx_data0 = '0; tx_ack0 = '1; tbl_val = 3'd0;
        rx_req1  = '0; rx_data1 = '0; tx_ack1 = '1;

        // reset state
        #12;
        chk("rst_tx_req0", 64'(tx_req0), 64'd0);
        chk("rst_tx_data0", 64'(tx_data0), 64'd0);
        chk("rst_table_addr0", 64'(table_addr0), 64'd0);
        chk("rst_drop0", 64'(drop_count0), 64'd0);
        chk("rst_rx_ack0", 64'(rx_ack0), 64'd0);
        chk("rst_rx_ack1", 64'(rx_ack1), 64'd0);
        chk("rst_tx_req1", 64'(tx_req1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        @(negedge clk);
        chk("post_rst_rx_ack0", 64'(rx_ack0), 64'h1F);
        chk("post_rst_rx_ack1", 64'(rx_ack1), 64'h7);

        // single flit: port 4 -> output 2
        do_reset();
        tbl_val = 3'd2;
        tx_ack0 = '1;
        send0(4, 8'h23, 3, ok);
        chk("t1_accept", 64'(ok), 64'd1);
        @(negedge clk);
        chk("t1_table_addr", 64'(table_addr0), 64'h23);
        chk("t1_tx_req_e0", 64'(tx_req0), 64'd0);
        @(negedge clk);
        chk("t1_tx_req_e1", 64'(tx_req0), 64'd0);
        @(negedge clk);
        chk("t1_tx_req_e2", 64'(tx_req0), 64'h04);
        chk("t1_tx_data", 64'(tx_data0[23:16]), 64'h23);
        @(negedge clk);
        chk("t1_tx_req_done", 64'(tx_req0), 64'd0);

        // fill and backpressure on output 0
        do_reset();
        tbl_val = 3'd0;
        tx_ack0 = 5'b11110;
        for (int i = 0; i < 5; i++) begin
            send0(1, 8'(8'hA0 + i), 4, ok);
            chk("bp_accept", 64'(ok), 64'd1);
        end
        repeat (6) sync();
        @(negedge clk);
        chk("bp_rx_ack_full", 64'(rx_ack0[1]), 64'd0);
        chk("bp_tx_req_held", 64'(tx_req0), 64'h01);
        chk("bp_tx_data_held", 64'(tx_data0[7:0]), 64'hA0);
        sync();
        send0(1, 8'hA5, 5, ok);
        chk("bp_sixth_blocked", 64'(ok), 64'd0);
        tx_ack0 = '1;
        collect0(0, 20);
        chk("bp_count", 64'(got0.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            g = (i < got0.size()) ? got0[i] : 8'h00;
            chk("bp_order", 64'(g), 64'(8'hA0 + i));
        end

        // round robin: 0, 1, 3 all to output 4
        do_reset();
        tbl_val = 3'd4;
        tx_ack0 = '1;
        fork
            stream0(0);
            stream0(1);
            stream0(3);
            collect0(4, 34);
        join
        chk("rr_count", 64'(got0.size() >= 27), 64'd1);
        for (int i = 0; i < 27; i++) begin
            src = (i < got0.size()) ? int'(got0[i][7:5]) : 7;
            chk("rr_order", 64'(src), 64'(rr_pat[i % 3]));
        end
        repeat (20) sync();

        // invalid route, then drop counter saturation
        do_reset();
        tbl_val = 3'd6;
        tx_ack0 = '1;
        send0(2, 8'h55, 3, ok);
        chk("inv_accept", 64'(ok), 64'd1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (tx_req0 != '0) seen = 1'b1;
        end
        chk("inv_no_tx", 64'(seen), 64'd0);
        chk("inv_drop_count", 64'(drop_count0), 64'd1);
        chk("inv_fifo_empty", 64'(table_addr0), 64'd0);
        sync();
        rx_data0 = 40'h0102030405;
        rx_req0  = '1;
        repeat (65600) @(posedge clk);
        @(negedge clk);
        chk("sat_drop_count", 64'(drop_count0), 64'hFFFF);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("sat_drop_hold", 64'(drop_count0), 64'hFFFF);
        chk("sat_no_tx", 64'(tx_req0), 64'd0);
        sync();
        rx_req0 = '0;

        // asynchronous reset mid-traffic
        do_reset();
        tbl_val = 3'd1;
        tx_ack0 = 5'b11101;
        fork
            for (int i = 0; i < 3; i++) begin bit a; send0(0, 8'(8'h10 + i), 10, a); end
            for (int i = 0; i < 3; i++) begin bit b; send0(2, 8'(8'h20 + i), 10, b); end
        join
        repeat (6) sync();
        @(negedge clk);
        chk("ar_stalled", 64'(tx_req0[1]), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_tx_req", 64'(tx_req0), 64'd0);
        chk("ar_rx_ack", 64'(rx_ack0), 64'd0);
        chk("ar_tx_data", 64'(tx_data0), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        @(negedge clk);
        chk("ar_rx_ack_after", 64'(rx_ack0), 64'h1F);
        chk("ar_fifos_empty", 64'(table_addr0), 64'd0);
        chk("ar_tx_req_after", 64'(tx_req0), 64'd0);
        sync();
        tx_ack0 = '1;
        fork
            begin bit c; send0(3, 8'hC7, 3, c); end
            collect0(1, 10);
        join
        chk("ar_new_count", 64'(got0.size()), 64'd1);
        g = (got0.size() > 0) ? got0[0] : 8'h00;
        chk("ar_new_flit", 64'(g), 64'hC7);

        // randomized traffic on the small instance
        do_reset();
        fork
            monitor1();
            ack_driver1();
        join_none
        fork
            sender1(0);
            sender1(1);
            sender1(2);
        join
        rnd_drain = 1'b1;
        repeat (200) sync();
        rnd_stop = 1'b1;
        repeat (3) sync();
        for (int q = 0; q < 9; q++) chk("rnd_leftover", 64'(expq[q].size()), 64'd0);
        chk("rnd_drops", 64'(drop_count1), 64'(drops_exp));
        chk("rnd_idle", 64'(tx_req1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
